regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite / WriteRegister / WriteData) between N_SRC writeback requesters, e.g. ALU, load unit and mult/div unit.
- Arbitration is round-robin, with a valid/ready handshake per source.
- A one-entry registered output stage drives the register file, so the write happens on the clock edge after the output stage is loaded.
- Exposes the in-flight write for bypass and hazard logic.

Parameters:
- N_SRC, 3, number of writeback requesters (2..8).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_valid  in  N_SRC  per-source write request.
- src_addr  in  N_SRC*ADDR_W  per-source destination register; source k occupies bits [k*ADDR_W +: ADDR_W].
- src_data  in  N_SRC*DATA_W  per-source write data, packed the same way.
- src_ready  out  N_SRC  one-hot grant; the transfer for source k occurs when src_valid[k] and src_ready[k] are both high.
- hold  in  1  when high, no grants are issued; the already-loaded output stage still drains.
- RegWrite  out  1  register-file write enable.
- WriteRegister  out  ADDR_W  register-file write address.
- WriteData  out  DATA_W  register-file write data.
- wb_busy  out  1  high when the output stage holds a pending write (same timing as RegWrite).
- grant_src  out  3  index of the source captured in the output stage; valid only while wb_busy is high.

Behaviour:
- Reset (rst low, asynchronous):
  - RegWrite=0, WriteRegister=0, WriteData=0, wb_busy=0, grant_src=0.
  - Round-robin pointer rr_ptr=0.
  - src_ready is combinational and is therefore 0 while reset is asserted.
  - Reset asserted mid-operation discards the pending write; no partial write is issued.
- Grant (combinational, same cycle):
  - If hold=0, pick the first k with src_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo N_SRC.
  - Drive src_ready[k]=1; all other src_ready bits are 0.
  - If hold=1 or no source is valid, src_ready is all zeros.
  - src_ready must not depend on src_data or src_addr.
  - A granted request is always accepted (the output stage empties every cycle), so there is no backpressure beyond arbitration.
- Capture (registered): on the edge where source k transfers:
  - WriteRegister<=src_addr[k], WriteData<=src_data[k], grant_src<=k, wb_busy<=1.
  - RegWrite<=1 only if src_addr[k]!=0. Writes to r0 are accepted and consumed but suppressed, so RegWrite stays 0 while wb_busy is 1.
  - rr_ptr<=(k+1) mod N_SRC.
- No transfer in a cycle: RegWrite<=0 and wb_busy<=0 on the next edge. WriteRegister and WriteData hold their last values.
- Latency: request accepted at edge T; RegWrite is high during cycle T..T+1; the register file commits at edge T+1. Throughput is one write per cycle.
- Ordering: writes are committed to the register file in grant order. Two sources targeting the same register in consecutive grants give last-granted-wins.
- Fairness: a continuously valid source is granted within N_SRC cycles while hold=0.
- A source that drops src_valid without a grant loses nothing; requests are not latched until granted.
- rr_ptr does not advance while hold=1 or while there is no transfer.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - ZERO_REG=5'd0.
  - A writeback request typedef with fields addr and data.
- Sub-module rr_arbiter (parameter N) handles the request vector, the enable (from ~hold), the grant one-hot and the pointer update. Its pointer resets asynchronously on rst low.
- The top level contains the output stage and the r0 suppression.

Test Plan:
- Single source: src0 valid, addr=5, data=0xDEADBEEF for one cycle.
  - Required: src_ready=3'b001 that cycle.
  - Next cycle: RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF, grant_src=0.
  - Cycle after: RegWrite=0.
- Round-robin: all three sources valid continuously with addrs 1, 2, 3, starting from reset.
  - Required grant sequence 0,1,2,0,1,2; RegWrite high every cycle.
  - WriteRegister sequence 1,2,3,1,2,3, delayed by one cycle.
- r0 suppression: src1 writes addr=0, data=0x12345678.
  - Required: src_ready[1]=1; next cycle wb_busy=1, RegWrite=0, grant_src=1.
  - A subsequent register-file read of r0 returns 0.
- Hold: all sources valid, hold=1 for 4 cycles, then 0.
  - Required during hold: src_ready=0 and RegWrite=0 after the stage drains; rr_ptr unchanged.
  - Required after release: first grant goes to the source indicated by the pre-hold rr_ptr.
- Reset mid-operation: rst low asynchronously, in the same cycle src2 is granted with addr=7.
  - Required: RegWrite, wb_busy and src_ready go to 0 immediately, before the next edge, and stay 0 while rst is low.
  - No write to r7 occurs; after release the first grant goes to source 0.
- Same-address collision: src0 then src1 write addr=9 with data 0xA then 0xB in back-to-back grants.
  - Required: RegWrite pulses two consecutive cycles.
  - r9 reads 0xB afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  // r0 is hardwired to zero; writes to it are consumed but never reach the file.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant chosen by scanning from rr_ptr upward with
// wrap-around; the pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [2:0]   gnt_idx,
  output logic         gnt_valid
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;

  // Rotating-priority scan: first requester at or after rr_ptr wins.
  always_comb begin
    // NOTE: every output gets a default before any condition, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (!gnt_valid && req[(int'(rr_ptr_q) + i) % N]) begin
          gnt_valid                        = 1'b1;
          gnt_idx                          = 3'((int'(rr_ptr_q) + i) % N);
          gnt[(int'(rr_ptr_q) + i) % N]    = 1'b1;
        end
      end
    end
  end

  // Pointer moves to the source just after the winner; otherwise it holds.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      rr_ptr_d = (int'(gnt_idx) == N - 1) ? '0 : PTR_W'(int'(gnt_idx) + 1);
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register file's single write port among N_SRC
// requesters through a round-robin grant and a one-entry registered stage.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_SRC  = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*ADDR_W-1:0] src_addr,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  input  logic                    hold,
  output logic                    RegWrite,
  output logic [ADDR_W-1:0]       WriteRegister,
  output logic [DATA_W-1:0]       WriteData,
  output logic                    wb_busy,
  output logic [2:0]              grant_src
);

  logic              arb_en;
  logic [N_SRC-1:0]  gnt;
  logic [2:0]        gnt_idx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              reg_write_q,      reg_write_d;
  logic              wb_busy_q,        wb_busy_d;
  logic [ADDR_W-1:0] write_register_q, write_register_d;
  logic [DATA_W-1:0] write_data_q,     write_data_d;
  logic [2:0]        grant_src_q,      grant_src_d;

  // Grants are suppressed while held and while reset is asserted, so src_ready
  // is zero during reset even though it is purely combinational.
  assign arb_en = ~hold & rst;

  rr_arbiter #(
    .N (N_SRC)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req       (src_valid),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (xfer)
  );

  assign src_ready = gnt;

  // One-hot mux of the granted source's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (gnt[k]) begin
        sel_addr = src_addr[k*ADDR_W +: ADDR_W];
        sel_data = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage next state: load on transfer, otherwise drain; r0 writes are
  // consumed but never raise the write enable.
  always_comb begin
    wb_busy_d        = xfer;
    reg_write_d      = xfer && (sel_addr != ADDR_W'(ZERO_REG));
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    grant_src_d      = grant_src_q;
    if (xfer) begin
      write_register_d = sel_addr;
      write_data_d     = sel_data;
      grant_src_d      = gnt_idx;
    end
  end

  // Output stage register; reset discards any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the address/data payload is reset too because it is visible on
      // the register-file port and to bypass logic; control alone is not enough.
      reg_write_q      <= 1'b0;
      wb_busy_q        <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      grant_src_q      <= '0;
    end else begin
      reg_write_q      <= reg_write_d;
      wb_busy_q        <= wb_busy_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      grant_src_q      <= grant_src_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign wb_busy       = wb_busy_q;
  assign WriteRegister = write_register_q;
  assign WriteData     = write_data_q;
  assign grant_src     = grant_src_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a behavioural reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N = 3;
  localparam int A = 5;
  localparam int D = 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   src_valid;
  logic [N*A-1:0] src_addr;
  logic [N*D-1:0] src_data;
  logic [N-1:0]   src_ready;
  logic           hold;
  logic           RegWrite;
  logic [A-1:0]   WriteRegister;
  logic [D-1:0]   WriteData;
  logic           wb_busy;
  logic [2:0]     grant_src;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int      m_ptr;
  logic    m_busy;
  logic    m_we;
  wb_req_t m_req;
  int      m_gsrc;
  logic [D-1:0] m_rf [NUM_REGS];

  // Register file driven by the DUT's write port
  logic [D-1:0] rf [NUM_REGS];

  regfile_wb_arbiter #(.N_SRC(N), .DATA_W(D), .ADDR_W(A)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid     (src_valid),
    .src_addr      (src_addr),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .hold          (hold),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .wb_busy       (wb_busy),
    .grant_src     (grant_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (RegWrite) rf[WriteRegister] <= WriteData;
  end

  function automatic logic [N*A-1:0] pa(input int a0, input int a1, input int a2);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [N*D-1:0] pd(input logic [D-1:0] d0, input logic [D-1:0] d1,
                                        input logic [D-1:0] d2);
    return {d2, d1, d0};
  endfunction

  // Winner is the first valid source at or after the model pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input logic h);
    if (h) return -1;
    for (int i = 0; i < N; i++) begin
      if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr  = 0;
    m_busy = 1'b0;
    m_we   = 1'b0;
    m_req  = '0;
    m_gsrc = 0;
  endfunction

  // One clock cycle: drive at the falling edge, check grant, then check the stage.
  task automatic cycle(input logic [N-1:0] v, input logic [N*A-1:0] a,
                       input logic [N*D-1:0] d, input logic h, input string tag);
    int k;
    logic [N-1:0] er;
    src_valid = v;
    src_addr  = a;
    src_data  = d;
    hold      = h;
    #1;
    k  = model_pick(v, h);
    er = '0;
    if (k >= 0) er[k] = 1'b1;
    tests++;
    if (src_ready !== er) begin
      fails++;
      $display("FAIL %s src_ready: got %b expected %b", tag, src_ready, er);
    end
    @(posedge clk);
    if (m_we) m_rf[m_req.addr] = m_req.data;
    if (k >= 0) begin
      m_busy     = 1'b1;
      m_req.addr = a[k*A +: A];
      m_req.data = d[k*D +: D];
      m_we       = (m_req.addr != ZERO_REG);
      m_gsrc     = k;
      m_ptr      = (k + 1) % N;
    end else begin
      m_busy = 1'b0;
      m_we   = 1'b0;
    end
    #1;
    tests++;
    if (RegWrite !== m_we) begin
      fails++;
      $display("FAIL %s RegWrite: got %b expected %b", tag, RegWrite, m_we);
    end
    tests++;
    if (wb_busy !== m_busy) begin
      fails++;
      $display("FAIL %s wb_busy: got %b expected %b", tag, wb_busy, m_busy);
    end
    tests++;
    if (WriteRegister !== m_req.addr || WriteData !== m_req.data) begin
      fails++;
      $display("FAIL %s write port: got r%0d=%h expected r%0d=%h", tag,
               WriteRegister, WriteData, m_req.addr, m_req.data);
    end
    if (m_busy) begin
      tests++;
      if (grant_src !== 3'(m_gsrc)) begin
        fails++;
        $display("FAIL %s grant_src: got %0d expected %0d", tag, grant_src, m_gsrc);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cycle('0, '0, '0, 1'b0, tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    hold      = 1'b0;
    model_reset();
    #1;
    tests++;
    if (RegWrite !== 1'b0 || wb_busy !== 1'b0 || WriteRegister !== '0 ||
        WriteData !== '0 || grant_src !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b busy=%b r%0d=%h src=%0d expected all zero",
               RegWrite, wb_busy, WriteRegister, WriteData, grant_src);
    end
    src_valid = '1;
    #1;
    tests++;
    if (src_ready !== '0) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 000", src_ready);
    end
    src_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    cycle(3'b001, pa(5, 0, 0), pd(32'hDEADBEEF, 0, 0), 1'b0, "single");
    tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF ||
        grant_src !== 3'd0) begin
      fails++;
      $display("FAIL single_capture: got we=%b r%0d=%h src=%0d expected we=1 r5=deadbeef src=0",
               RegWrite, WriteRegister, WriteData, grant_src);
    end
    idle("single_drain");
    tests++;
    if (RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL single_drain_we: got %b expected 0", RegWrite);
    end
    tests++;
    if (rf[5] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_commit r5: got %h expected deadbeef", rf[5]);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(3'b111, pa(1, 2, 3), pd($urandom, $urandom, $urandom), 1'b0, "rr");
      tests++;
      if (grant_src !== 3'(i % 3) || WriteRegister !== 5'(i % 3 + 1) || RegWrite !== 1'b1) begin
        fails++;
        $display("FAIL rr_seq[%0d]: got src=%0d r%0d we=%b expected src=%0d r%0d we=1",
                 i, grant_src, WriteRegister, RegWrite, i % 3, i % 3 + 1);
      end
    end
    idle("rr_drain");
  endtask

  task automatic test_r0_suppress();
    cycle(3'b010, pa(0, 0, 0), pd(0, 32'h12345678, 0), 1'b0, "r0");
    tests++;
    if (wb_busy !== 1'b1 || RegWrite !== 1'b0 || grant_src !== 3'd1) begin
      fails++;
      $display("FAIL r0_capture: got busy=%b we=%b src=%0d expected busy=1 we=0 src=1",
               wb_busy, RegWrite, grant_src);
    end
    idle("r0_drain");
    tests++;
    if (rf[0] !== 32'h0) begin
      fails++;
      $display("FAIL r0_read: got %h expected 0", rf[0]);
    end
  endtask

  task automatic test_hold();
    // Leave the pointer at source 2 by granting source 1 alone.
    cycle(3'b010, pa(0, 6, 0), pd(0, 32'h66, 0), 1'b0, "pre_hold");
    for (int i = 0; i < 4; i++) begin
      cycle(3'b111, pa(12, 13, 14), pd(1, 2, 3), 1'b1, "hold");
      tests++;
      if (RegWrite !== 1'b0 || wb_busy !== 1'b0) begin
        fails++;
        $display("FAIL hold_drained[%0d]: got we=%b busy=%b expected 0 0", i, RegWrite, wb_busy);
      end
    end
    cycle(3'b111, pa(12, 13, 14), pd(1, 2, 3), 1'b0, "hold_release");
    tests++;
    if (grant_src !== 3'd2) begin
      fails++;
      $display("FAIL hold_first_grant: got %0d expected 2", grant_src);
    end
    idle("hold_drain");
  endtask

  task automatic test_back_to_back();
    cycle(3'b001, pa(9, 0, 0), pd(32'hA, 0, 0), 1'b0, "collide0");
    cycle(3'b010, pa(0, 9, 0), pd(0, 32'hB, 0), 1'b0, "collide1");
    idle("collide_drain");
    tests++;
    if (rf[9] !== 32'hB) begin
      fails++;
      $display("FAIL collide_r9: got %h expected 0000000b", rf[9]);
    end
  endtask

  task automatic test_reset_mid();
    cycle(3'b001, pa(11, 0, 0), pd(32'hB0B0, 0, 0), 1'b0, "pre_rst");
    src_valid = 3'b100;
    src_addr  = pa(0, 0, 7);
    src_data  = pd(0, 0, 32'h77);
    #1;
    tests++;
    if (src_ready !== 3'b100 || RegWrite !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: got ready=%b we=%b expected 100 1", src_ready, RegWrite);
    end
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    tests++;
    if (src_ready !== '0 || RegWrite !== 1'b0 || wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async: got ready=%b we=%b busy=%b expected 000 0 0",
               src_ready, RegWrite, wb_busy);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (src_ready !== '0 || RegWrite !== 1'b0 || wb_busy !== 1'b0 || WriteRegister !== '0) begin
        fails++;
        $display("FAIL rst_mid_hold[%0d]: got ready=%b we=%b busy=%b r%0d expected zeros",
                 i, src_ready, RegWrite, wb_busy, WriteRegister);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    cycle(3'b111, pa(20, 21, 22), pd(4, 5, 6), 1'b0, "rst_release");
    tests++;
    if (grant_src !== 3'd0) begin
      fails++;
      $display("FAIL rst_first_grant: got %0d expected 0", grant_src);
    end
    idle("rst_drain");
    tests++;
    if (rf[7] !== 32'h0 || rf[11] !== 32'h0) begin
      fails++;
      $display("FAIL rst_no_write: got r7=%h r11=%h expected 0 0", rf[7], rf[11]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(3'($urandom), pa($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)),
            pd($urandom, $urandom, $urandom), ($urandom_range(0, 4) == 0), "random");
    end
    idle("random_drain");
    for (int r = 0; r < NUM_REGS; r++) begin
      tests++;
      if (rf[r] !== m_rf[r]) begin
        fails++;
        $display("FAIL rf_final r%0d: got %h expected %h", r, rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) begin
      rf[r]   = '0;
      m_rf[r] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_r0_suppress();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
